eth_tx_arb: RTL and testbench

Round-robin packet arbiter placed in front of the Ethernet RMII transmit path. It shares the single transmit byte input (10-bit word: data, EOP, SOP) between up to `pNUM_SRC` packet sources. It grants one source at a time and guarantees that every byte of a packet reaches the transmit FIFO on consecutive cycles. It also closes malformed packets (underrun, over-length) and enforces an inter-packet gap and FIFO back-pressure.

---
 rtl/eth_tx_arb.sv | 209 ++++++++++++++++++++
 tb/tb_eth_tx_arb.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_arb.sv
// eth_tx_arb: round-robin packet arbiter feeding the RMII transmit byte path.
// Closes underrun and over-length packets and enforces an inter-packet gap.
module eth_tx_arb #(
    parameter int pNUM_SRC    = 2,
    parameter int pMAX_LEN    = 1500,
    parameter int pGAP_CYCLES = 4
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [pNUM_SRC-1:0]   Src_Req,
    output logic [pNUM_SRC-1:0]   Src_Grant,
    input  logic [8*pNUM_SRC-1:0] Src_Data,
    input  logic [pNUM_SRC-1:0]   Src_Valid,
    input  logic [pNUM_SRC-1:0]   Src_Last,
    input  logic                  Fifo_Afull,
    output logic [9:0]            Eth_Byte,
    output logic                  Eth_Byte_Valid,
    output logic [2:0]            Active_Src,
    output logic                  Pkt_Done,
    output logic                  Underrun,
    output logic                  Truncated
);

    typedef enum logic [2:0] {
        IDLE, GRANT, XFER, DRAIN, GAP
    } tState;

    localparam logic [10:0] cMaxLen   = 11'(pMAX_LEN);
    localparam logic [7:0]  cGap      = 8'(pGAP_CYCLES);
    localparam logic [2:0]  cLastInit = 3'(pNUM_SRC - 1);

    tState                state, stateNxt;
    logic [2:0]           lastIdx, lastNxt;
    logic [2:0]           actNxt;
    logic [pNUM_SRC-1:0]  grantNxt;
    logic [10:0]          byteCnt, cntNxt;
    logic [7:0]           gapCnt, gapNxt;
    logic [9:0]           byteNxt;
    logic                 validNxt, doneNxt, underNxt, truncNxt;

    logic                 curReq, curValid, curLast;
    logic [7:0]           curData;
    logic [3:0]           start;
    logic                 hiFound, winFound;
    logic [2:0]           hiIdx, anyIdx, winIdx;
    logic [pNUM_SRC-1:0]  winOneHot;

    always_comb begin
        curReq   = 1'b0;
        curValid = 1'b0;
        curLast  = 1'b0;
        curData  = '0;
        for (int i = 0; i < pNUM_SRC; i++) begin
            if (Active_Src == 3'(i)) begin
                curReq   = Src_Req[i];
                curValid = Src_Valid[i];
                curLast  = Src_Last[i];
                curData  = Src_Data[8*i +: 8];
            end
        end
    end

    // Lowest requester at or above lastIdx+1, else wrap to lowest overall.
    always_comb begin
        start   = {1'b0, lastIdx} + 4'd1;
        hiFound = 1'b0;
        hiIdx   = '0;
        anyIdx  = '0;
        for (int i = pNUM_SRC - 1; i >= 0; i--) begin
            if (Src_Req[i]) begin
                anyIdx = 3'(i);
            end
            if (Src_Req[i] && (4'(i) >= start)) begin
                hiFound = 1'b1;
                hiIdx   = 3'(i);
            end
        end
        winFound = |Src_Req;
        winIdx   = hiFound ? hiIdx : anyIdx;
    end

    always_comb begin
        winOneHot = '0;
        for (int i = 0; i < pNUM_SRC; i++) begin
            winOneHot[i] = (winIdx == 3'(i));
        end
    end

    always_comb begin
        stateNxt = state;
        grantNxt = Src_Grant;
        actNxt   = Active_Src;
        lastNxt  = lastIdx;
        cntNxt   = byteCnt;
        gapNxt   = gapCnt;
        byteNxt  = '0;
        validNxt = 1'b0;
        doneNxt  = 1'b0;
        underNxt = 1'b0;
        truncNxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (winFound && !Fifo_Afull) begin
                    grantNxt = winOneHot;
                    actNxt   = winIdx;
                    stateNxt = GRANT;
                end
            end
            GRANT: begin
                if (curValid) begin
                    validNxt = 1'b1;
                    byteNxt  = {1'b1, curLast, curData};
                    cntNxt   = 11'd1;
                    if (curLast) begin
                        doneNxt  = 1'b1;
                        grantNxt = '0;
                        lastNxt  = Active_Src;
                        gapNxt   = '0;
                        stateNxt = GAP;
                    end else if (cMaxLen == 11'd1) begin
                        byteNxt[8] = 1'b1;
                        doneNxt    = 1'b1;
                        truncNxt   = 1'b1;
                        stateNxt   = DRAIN;
                    end else begin
                        stateNxt = XFER;
                    end
                end else if (!curReq) begin
                    grantNxt = '0;
                    stateNxt = IDLE;
                end
            end
            XFER: begin
                validNxt = 1'b1;
                if (!curValid) begin
                    // Underrun appends a zero byte carrying EOP.
                    byteNxt  = 10'h100;
                    doneNxt  = 1'b1;
                    underNxt = 1'b1;
                    grantNxt = '0;
                    lastNxt  = Active_Src;
                    gapNxt   = '0;
                    stateNxt = GAP;
                end else begin
                    byteNxt = {1'b0, curLast, curData};
                    cntNxt  = byteCnt + 11'd1;
                    if (curLast) begin
                        doneNxt  = 1'b1;
                        grantNxt = '0;
                        lastNxt  = Active_Src;
                        gapNxt   = '0;
                        stateNxt = GAP;
                    end else if (byteCnt + 11'd1 == cMaxLen) begin
                        byteNxt[8] = 1'b1;
                        doneNxt    = 1'b1;
                        truncNxt   = 1'b1;
                        stateNxt   = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (curValid && curLast) begin
                    grantNxt = '0;
                    lastNxt  = Active_Src;
                    gapNxt   = '0;
                    stateNxt = GAP;
                end
            end
            GAP: begin
                grantNxt = '0;
                if (gapCnt == cGap) begin
                    stateNxt = IDLE;
                end else begin
                    gapNxt = gapCnt + 8'd1;
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state          <= IDLE;
            lastIdx        <= cLastInit;
            Src_Grant      <= '0;
            Active_Src     <= '0;
            byteCnt        <= '0;
            gapCnt         <= '0;
            Eth_Byte       <= '0;
            Eth_Byte_Valid <= 1'b0;
            Pkt_Done       <= 1'b0;
            Underrun       <= 1'b0;
            Truncated      <= 1'b0;
        end else begin
            state          <= stateNxt;
            lastIdx        <= lastNxt;
            Src_Grant      <= grantNxt;
            Active_Src     <= actNxt;
            byteCnt        <= cntNxt;
            gapCnt         <= gapNxt;
            Eth_Byte       <= byteNxt;
            Eth_Byte_Valid <= validNxt;
            Pkt_Done       <= doneNxt;
            Underrun       <= underNxt;
            Truncated      <= truncNxt;
        end
    end

endmodule

// File: tb/tb_eth_tx_arb.sv
// tb_eth_tx_arb: directed bench for eth_tx_arb with a byte scoreboard.
// Two instances differ only in max length; one is selected for checking.
module tb_eth_tx_arb;

    localparam int NS   = 2;
    localparam int GAP  = 4;
    localparam int MAXA = 1500;
    localparam int MAXB = 16;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic [NS-1:0] Src_Req;
    logic [NS-1:0] Src_Valid;
    logic [NS-1:0] Src_Last;
    logic [8*NS-1:0] Src_Data;
    logic          Fifo_Afull;

    logic [NS-1:0] gA, gB, gS;
    logic [9:0]    byteA, byteB, byteS;
    logic          vA, vB, vS;
    logic [2:0]    actA, actB, actS;
    logic          doneA, doneB, doneS;
    logic          underA, underB, underS;
    logic          truncA, truncB, truncS;
    logic          useB = 1'b0;

    always #5 Clk = ~Clk;

    eth_tx_arb #(
        .pNUM_SRC(NS), .pMAX_LEN(MAXA), .pGAP_CYCLES(GAP)
    ) dutA (
        .Clk(Clk), .Rst(Rst),
        .Src_Req(Src_Req), .Src_Grant(gA),
        .Src_Data(Src_Data), .Src_Valid(Src_Valid),
        .Src_Last(Src_Last), .Fifo_Afull(Fifo_Afull),
        .Eth_Byte(byteA), .Eth_Byte_Valid(vA),
        .Active_Src(actA), .Pkt_Done(doneA),
        .Underrun(underA), .Truncated(truncA)
    );

    eth_tx_arb #(
        .pNUM_SRC(NS), .pMAX_LEN(MAXB), .pGAP_CYCLES(GAP)
    ) dutB (
        .Clk(Clk), .Rst(Rst),
        .Src_Req(Src_Req), .Src_Grant(gB),
        .Src_Data(Src_Data), .Src_Valid(Src_Valid),
        .Src_Last(Src_Last), .Fifo_Afull(Fifo_Afull),
        .Eth_Byte(byteB), .Eth_Byte_Valid(vB),
        .Active_Src(actB), .Pkt_Done(doneB),
        .Underrun(underB), .Truncated(truncB)
    );

    assign gS     = useB ? gB : gA;
    assign byteS  = useB ? byteB : byteA;
    assign vS     = useB ? vB : vA;
    assign actS   = useB ? actB : actA;
    assign doneS  = useB ? doneB : doneA;
    assign underS = useB ? underB : underA;
    assign truncS = useB ? truncB : truncA;

    bit         req[NS], hold[NS], lg[NS], lv[NS];
    int         len[NS], drop[NS], sent[NS], pkts[NS];
    logic [7:0] base[NS];

    int total = 0;
    int bad = 0;
    logic [12:0] sbq[$];
    int validCnt, doneCnt, underCnt, truncCnt;
    int firstCyc, lastCyc;
    int cyc = 0;
    int sopLog[$];
    int sopCyc[$];
    int eopCyc[$];

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < NS; i++) begin
            req[i]  = 0;
            hold[i] = 0;
            lg[i]   = 0;
            lv[i]   = 0;
            len[i]  = 0;
            drop[i] = 0;
            sent[i] = 0;
            pkts[i] = 0;
            base[i] = 8'h00;
        end
        Src_Req    = '0;
        Src_Valid  = '0;
        Src_Last   = '0;
        Src_Data   = '0;
        Fifo_Afull = 1'b0;
    endtask

    task automatic clearStats();
        validCnt = 0;
        doneCnt  = 0;
        underCnt = 0;
        truncCnt = 0;
        firstCyc = -1;
        lastCyc  = -1;
        sopLog.delete();
        sopCyc.delete();
        eopCyc.delete();
    endtask

    task automatic endPkt(input int i);
        sent[i] = 0;
        drop[i] = 0;
        pkts[i] = pkts[i] - 1;
        if (pkts[i] <= 0) begin
            pkts[i] = 0;
            req[i]  = 0;
        end
    endtask

    // One cycle of the source models: account for last edge, drive next.
    task automatic step();
        int k;
        int mx;
        logic eop, tr;
        logic [7:0] d;
        @(negedge Clk);
        mx = useB ? MAXB : MAXA;
        for (int i = 0; i < NS; i++) begin
            if (lg[i] && lv[i]) begin
                k   = sent[i] + 1;
                d   = 8'(int'(base[i]) + sent[i]);
                tr  = (k == mx) && (k < len[i]);
                eop = (k == len[i]) || tr;
                if (k <= mx)
                    sbq.push_back({eop, 1'b0, tr, (k == 1), eop, d});
                sent[i] = k;
                if (k == len[i]) endPkt(i);
            end else if (lg[i] && !lv[i] && sent[i] > 0
                         && sent[i] < mx) begin
                sbq.push_back({1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00});
                endPkt(i);
            end
        end
        for (int i = 0; i < NS; i++) begin
            Src_Req[i]   = req[i];
            Src_Valid[i] = req[i] && !hold[i]
                           && !(drop[i] != 0 && sent[i] == drop[i]);
            Src_Last[i]  = (sent[i] + 1 == len[i]);
            Src_Data[8*i +: 8] = 8'(int'(base[i]) + sent[i]);
            lg[i] = gS[i];
            lv[i] = Src_Valid[i];
        end
    endtask

    task automatic steps(input int n);
        for (int j = 0; j < n; j++) step();
    endtask

    task automatic waitDone(input int i, input int budget);
        int c = 0;
        while (pkts[i] != 0 && c < budget) begin
            step();
            c++;
        end
        check($sformatf("timeout_src%0d", i), 32'(pkts[i]), 0);
    endtask

    task automatic checkZero(input string tag);
        check({tag, "_grant"}, 32'(gS), 0);
        check({tag, "_valid"}, 32'(vS), 0);
        check({tag, "_byte"}, 32'(byteS), 0);
        check({tag, "_act"}, 32'(actS), 0);
        check({tag, "_pulses"}, 32'({doneS, underS, truncS}), 0);
    endtask

    task automatic resetDut();
        @(negedge Clk);
        Rst = 1'b1;
        clearModel();
        #1;
        checkZero("rst");
        @(negedge Clk);
        sbq.delete();
        clearStats();
        Rst = 1'b0;
    endtask

    always @(negedge Clk) begin : mon
        logic [12:0] obs, e;
        cyc++;
        if (!Rst && (vS || doneS || underS || truncS)) begin
            obs = {doneS, underS, truncS, byteS};
            if (sbq.size() == 0) begin
                check("unexpected_out", 32'(obs), 0);
            end else begin
                e = sbq.pop_front();
                check("out", 32'(obs), 32'(e));
            end
            if (vS) begin
                validCnt++;
                if (firstCyc < 0) firstCyc = cyc;
                lastCyc = cyc;
            end
            if (vS && byteS[9]) begin
                sopLog.push_back(int'(actS));
                sopCyc.push_back(cyc);
            end
            if (vS && byteS[8]) eopCyc.push_back(cyc);
            if (doneS) doneCnt++;
            if (underS) underCnt++;
            if (truncS) truncCnt++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        clearModel();
        clearStats();

        // Single source, 60-byte packet.
        useB = 1'b0;
        resetDut();
        req[0] = 1; pkts[0] = 1; len[0] = 60; base[0] = 8'h00;
        waitDone(0, 200);
        check("t1_grant_off", 32'(gS[0]), 0);
        steps(GAP + 4);
        check("t1_count", validCnt, 60);
        check("t1_contig", lastCyc - firstCyc + 1, 60);
        check("t1_done", doneCnt, 1);
        check("t1_sb_empty", sbq.size(), 0);

        // Round-robin between two continuous requesters.
        resetDut();
        req[0] = 1; pkts[0] = 2; len[0] = 5; base[0] = 8'h10;
        req[1] = 1; pkts[1] = 2; len[1] = 5; base[1] = 8'h80;
        waitDone(0, 300);
        waitDone(1, 300);
        steps(GAP + 4);
        check("t2_sops", sopLog.size(), 4);
        for (int j = 0; j < sopLog.size() && j < 4; j++)
            check("t2_rr", sopLog[j], j % 2);
        for (int j = 0; j < 3 && j < eopCyc.size()
             && j + 1 < sopCyc.size(); j++)
            check("t2_gap", sopCyc[j+1] - eopCyc[j], GAP + 3);
        check("t2_sb_empty", sbq.size(), 0);

        // Underrun after the 10th byte of source 1.
        resetDut();
        req[1] = 1; pkts[1] = 1; len[1] = 20;
        drop[1] = 10; base[1] = 8'h40;
        waitDone(1, 200);
        steps(GAP + 4);
        check("t3_count", validCnt, 11);
        check("t3_under", underCnt, 1);
        check("t3_done", doneCnt, 1);
        check("t3_grant_off", 32'(gS), 0);
        req[1] = 1; pkts[1] = 1; len[1] = 3; base[1] = 8'h60;
        waitDone(1, 100);
        steps(GAP + 4);
        check("t3_after_idle", validCnt, 14);
        check("t3_sb_empty", sbq.size(), 0);

        // Truncation at 16 bytes of a 20-byte packet.
        useB = 1'b1;
        resetDut();
        req[0] = 1; pkts[0] = 1; len[0] = 20; base[0] = 8'hA0;
        c = 0;
        while (sent[0] < 18 && c < 100) begin
            step();
            c++;
        end
        check("t4_drain_grant", 32'(gS[0]), 1);
        waitDone(0, 100);
        check("t4_grant_off", 32'(gS[0]), 0);
        steps(GAP + 4);
        check("t4_count", validCnt, 16);
        check("t4_trunc", truncCnt, 1);
        check("t4_done", doneCnt, 1);
        check("t4_sb_empty", sbq.size(), 0);

        // Back-pressure, then release before the first byte.
        useB = 1'b0;
        resetDut();
        Fifo_Afull = 1'b1;
        req[0] = 1; pkts[0] = 1; len[0] = 4; base[0] = 8'h30;
        steps(5);
        check("t5_afull_nogrant", 32'(gS), 0);
        check("t5_afull_noout", validCnt, 0);
        Fifo_Afull = 1'b0;
        step();
        check("t5_grant_lat", 32'(gS), 1);
        Fifo_Afull = 1'b1;
        waitDone(0, 50);
        steps(GAP + 4);
        check("t5_inflight", validCnt, 4);
        Fifo_Afull = 1'b0;
        hold[1] = 1; req[1] = 1; pkts[1] = 1;
        len[1] = 2; base[1] = 8'h50;
        c = 0;
        while (!gS[1] && c < 20) begin
            step();
            c++;
        end
        check("t5_hold_grant", 32'(gS[1]), 1);
        req[1] = 0; pkts[1] = 0; hold[1] = 0;
        Src_Req[1] = 1'b0;
        step();
        check("t5_release", 32'(gS), 0);
        steps(3);
        check("t5_no_out", validCnt, 4);
        clearStats();
        req[0] = 1; pkts[0] = 1; len[0] = 2; base[0] = 8'h70;
        req[1] = 1; pkts[1] = 1; len[1] = 2; base[1] = 8'h78;
        waitDone(0, 100);
        waitDone(1, 100);
        steps(GAP + 4);
        check("t5_sops", sopLog.size(), 2);
        if (sopLog.size() > 0)
            check("t5_last_kept", sopLog[0], 1);
        check("t5_sb_empty", sbq.size(), 0);

        // Asynchronous reset in the middle of a packet.
        resetDut();
        req[0] = 1; pkts[0] = 1; len[0] = 3; base[0] = 8'h11;
        waitDone(0, 50);
        steps(GAP + 4);
        req[1] = 1; pkts[1] = 1; len[1] = 30; base[1] = 8'h22;
        c = 0;
        while (sent[1] < 5 && c < 50) begin
            step();
            c++;
        end
        check("t6_pre_valid", 32'(vS), 1);
        #2;
        Rst = 1'b1;
        #1;
        checkZero("t6_async");
        clearModel();
        sbq.delete();
        @(negedge Clk);
        clearStats();
        Rst = 1'b0;
        req[0] = 1; pkts[0] = 1; len[0] = 2; base[0] = 8'h33;
        req[1] = 1; pkts[1] = 1; len[1] = 2; base[1] = 8'h44;
        waitDone(0, 100);
        waitDone(1, 100);
        steps(GAP + 4);
        check("t6_sops", sopLog.size(), 2);
        if (sopLog.size() > 0)
            check("t6_first_src0", sopLog[0], 0);
        check("t6_sb_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
